// File: rtl/ssd_ctrl_pkg.sv
// Shared constants for the SSD controller slice: channel count, select width,
// arbiter state encoding and a one-hot helper.
package ssd_ctrl_pkg;

  localparam int unsigned N_CH = 16;
  localparam int unsigned CH_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic [N_CH-1:0] ch_onehot(input logic [CH_W-1:0] idx);
    ch_onehot      = '0;
    ch_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/ram_ch_arb_if.sv
// Channel-to-RAM arbitration bundle: requests from the NAND controllers and the
// grant/enable/done signals returned by the arbiter.
interface ram_ch_arb_if #(
  parameter int unsigned CNT_W = 8
);
  logic [ssd_ctrl_pkg::N_CH-1:0] ch_req;
  logic [ssd_ctrl_pkg::N_CH-1:0] ram_oe;
  logic [ssd_ctrl_pkg::CH_W-1:0] ch_num;
  logic                          busy;
  logic [CNT_W-1:0]              beat_cnt;
  logic [ssd_ctrl_pkg::N_CH-1:0] ch_done;

  modport master (
    input  ch_req,
    output ram_oe, ch_num, busy, beat_cnt, ch_done
  );

  modport slave (
    output ch_req,
    input  ram_oe, ch_num, busy, beat_cnt, ch_done
  );
endinterface

// File: rtl/rr_pick16.sv
// Combinational round-robin priority encoder: first requester found searching
// upward from last+1, wrapping 15 -> 0.
module rr_pick16 (
  input  logic [15:0] req,
  input  logic [3:0]  last,
  output logic [3:0]  grant_idx,
  output logic        grant_vld
);
  logic [3:0] cand;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last;
    cand      = '0;
    // 4-bit addition wraps naturally; i = 16 lands back on last itself.
    for (int unsigned i = 1; i <= 16; i++) begin
      cand = last + 4'(i);
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end
endmodule

// File: rtl/ram_ch_arb.sv
// Round-robin arbiter granting one of 16 flash channels the shared page RAM for
// a fixed burst. Define RAM_CH_ARB_ABORT_EN to end a burst early when the owner drops ch_req.
module ram_ch_arb #(
  parameter int unsigned N_CH      = 16,
  parameter int unsigned CH_W      = 4,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  ram_ch_arb_if.master        bus
);
  import ssd_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic [1:0]      state_q, state_d;
  logic [CH_W-1:0] ch_num_q, ch_num_d;
  logic [CH_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [N_CH-1:0] ram_oe_q, ram_oe_d;
  logic [N_CH-1:0] ch_done_q, ch_done_d;
  logic            busy_q, busy_d;

  logic [3:0]      pick_idx;
  logic            pick_vld;
  logic            abort;

  rr_pick16 u_pick (
    .req       (bus.ch_req),
    .last      (last_q),
    .grant_idx (pick_idx),
    .grant_vld (pick_vld)
  );

`ifdef RAM_CH_ARB_ABORT_EN
  assign abort = ~bus.ch_req[ch_num_q];
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ch_num_d   = ch_num_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    ram_oe_d   = ram_oe_q;
    busy_d     = busy_q;
    ch_done_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d    = ST_BURST;
          ch_num_d   = pick_idx;
          last_d     = pick_idx;
          beat_cnt_d = '0;
          ram_oe_d   = ch_onehot(pick_idx);
          busy_d     = 1'b1;
        end
      end
      ST_BURST: begin
        // beat_cnt holds its final/abort value through DONE.
        if (abort || beat_cnt_q == LAST_BEAT) begin
          state_d   = ST_DONE;
          ram_oe_d  = '0;
          busy_d    = 1'b0;
          ch_done_d = ch_onehot(ch_num_q);
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        ram_oe_d = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ch_num_q   <= '0;
      last_q     <= '1;
      beat_cnt_q <= '0;
      ram_oe_q   <= '0;
      ch_done_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_num_q   <= ch_num_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      ram_oe_q   <= ram_oe_d;
      ch_done_q  <= ch_done_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.ram_oe   = ram_oe_q;
  assign bus.ch_num   = ch_num_q;
  assign bus.busy     = busy_q;
  assign bus.beat_cnt = beat_cnt_q;
  assign bus.ch_done  = ch_done_q;

endmodule

// File: doc/ram_ch_arb.md
# ram_ch_arb

Round-robin arbiter that grants one of 16 flash channels exclusive access to the shared page RAM for a fixed-length burst. It drives the per-channel one-hot `ram_oe` vector and the `ch_num` select consumed by the RAM-side channel mux, which is the return path to the same RAM port. It sits between the per-channel NAND controllers (requesters) and the shared RAM read/write datapath.

## Interface
Parameters:
- `N_CH`, 16: number of channels. Fixed at 16 in this revision.
- `CH_W`, 4: width of `ch_num`.
- `BURST_LEN`, 8: RAM beats per grant. Legal range is 1..255.
- `CNT_W`, 8: width of the beat counter.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `ch_req`, input, 16: per-channel request level. A requester holds it high until its `ch_done` bit pulses.
- `ram_oe`, output, 16: one-hot RAM enable for the granted channel. It is all-zero when no channel owns the RAM.
- `ch_num`, output, 4: index of the granted channel. It holds its last value when idle.
- `busy`, output, 1: high while a burst is active. Equals OR of `ram_oe`.
- `beat_cnt`, output, `CNT_W`: beat index within the current burst, counting 0..BURST_LEN-1.
- `ch_done`, output, 16: one-cycle one-hot pulse marking the end of the granted channel's burst.

## Operation
- State machine states: IDLE, BURST, DONE.
- **IDLE**
  - If any `ch_req` bit is high, select the first requesting channel in round-robin order, searching from `last+1` upward and wrapping 15→0.
  - On the selection: latch `ch_num`, set `last` to the winner, clear `beat_cnt`, and go to BURST.
  - If no request is pending, stay in IDLE.
- **BURST**
  - `ram_oe[ch_num]` = 1 and `busy` = 1.
  - `beat_cnt` increments by 1 each cycle.
  - When `beat_cnt == BURST_LEN-1`, go to DONE.
- **DONE**
  - `ram_oe` = 0 and `ch_done[ch_num]` = 1 for exactly one cycle.
  - Then go to IDLE unconditionally.
- Requests arriving during BURST or DONE are only sampled in IDLE. There is no preemption.
- A requester that drops `ch_req` mid-burst has no effect unless `RAM_CH_ARB_ABORT_EN` is defined.
- Multiple `ch_req` bits rising in the same cycle: the lowest index at or after `last+1` (modulo 16) wins.
- The arbiter never asserts more than one `ram_oe` bit or one `ch_done` bit.
- Reset values:
  - state = IDLE, `ram_oe` = 0, `ch_done` = 0, `busy` = 0, `beat_cnt` = 0, `ch_num` = 0.
  - `last` = 15, so channel 0 has first priority after reset.
- Reset asserted mid-burst: all of the reset values above apply on the next edge. No `ch_done` pulse is issued for the aborted burst.

## Timing
- All outputs are registered.
- Request high at edge N, arbiter in IDLE:
  - `ram_oe` and `ch_num` are valid after edge N+1.
  - The burst occupies cycles N+1..N+BURST_LEN.
  - `ch_done` pulses in cycle N+BURST_LEN+1.
  - The next arbitration happens at edge N+BURST_LEN+2.
- Back-to-back grants leave a gap of 2 cycles with `ram_oe` = 0: the DONE cycle and the IDLE cycle.
- The requester must deassert `ch_req` on the edge where it sees `ch_done`. If `ch_req` is still high in IDLE, it is treated as a new request.
- With `BURST_LEN` = 1, BURST lasts a single cycle.

## Configuration
- Macro: `RAM_CH_ARB_ABORT_EN`.
- Defined:
  - In BURST, if `ch_req[ch_num]` = 0, the arbiter goes to DONE on the next edge.
  - `ram_oe` drops on that same edge, and `ch_done` still pulses.
  - `beat_cnt` freezes at the abort value during DONE.
- Not defined: `ch_req` is ignored during BURST, and every burst is exactly `BURST_LEN` beats.

## Structure
- Shared package `ssd_ctrl_pkg` holds:
  - the state encoding: IDLE = 2'd0, BURST = 2'd1, DONE = 2'd2;
  - the constants `N_CH` and `CH_W`.
- Sub-module `rr_pick16`: combinational round-robin priority encoder.
  - Inputs: `req[15:0]`, `last[3:0]`.
  - Outputs: `grant_idx[3:0]`, `grant_vld`.
  - The top level keeps the FSM, counter and registers.

## Test plan
- Reset, then hold `ch_req` = 16'h0000 for 10 cycles → `ram_oe` = 0, `busy` = 0 and `ch_done` = 0 throughout.
- With `BURST_LEN` = 8, `ch_req` = 16'h0020 → `ch_num` = 5 and `ram_oe` = 16'h0020 for 8 cycles, with `beat_cnt` 0..7. Then `ch_done` = 16'h0020 for one cycle.
- Right after reset, `ch_req` = 16'h8001 held → grant order is 0, 15, 0, 15, with 2 idle cycles between bursts.
- `ch_req` = 16'hFFFF held and each channel drops its request on `ch_done` → grants are issued in order 0..15 exactly once each. One-hot `ram_oe` is never violated.
- `rst` pulsed at beat 3 of a channel-7 burst → next cycle `ram_oe` = 0, no `ch_done`, and the next grant goes to the lowest requesting channel.
- With `RAM_CH_ARB_ABORT_EN` defined, channel 2 drops `ch_req` at beat 4 → `ram_oe` goes low on the next edge, followed by a single `ch_done` = 16'h0004 with `beat_cnt` = 4. Without the macro, the burst completes all 8 beats.
